// File: rtl/risk_memory_responder.sv
// Responder for the upstream order-flow handshake: runs risk checks, writes
// orders into an FWFT buffer, updates the max-exposure register and tracks
// the running exposure of buffered orders.
module risk_memory_responder #(
  parameter int QTY_W     = 16,
  parameter int PRICE_W   = 16,
  parameter int DEPTH     = 8,
  parameter int WR_CYCLES = 2,
  parameter int MAX_RESET = 1000
) (
  input  logic                     clk,
  input  logic                     HRESETn,
  input  logic                     check_risk,
  input  logic                     send_order,
  input  logic                     update_max,
  input  logic [QTY_W-1:0]         order_qty,
  input  logic [PRICE_W-1:0]       order_price,
  input  logic [QTY_W-1:0]         max_in,
  output logic                     risk_ok,
  output logic                     risk_valid,
  output logic                     memwr,
  output logic                     ord_reject,
  output logic [QTY_W-1:0]         cur_max,
  output logic [QTY_W:0]           exposure,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [QTY_W-1:0]         rd_qty,
  output logic [PRICE_W-1:0]       rd_price,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     buf_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
  localparam logic [WC_W-1:0]  WC_LOAD   = WC_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RISK,
    ORD_WR,
    MAX_WR,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [WC_W-1:0]    wcnt, wcnt_n;
  logic               risk_stage, risk_stage_n;
  logic               risk_ok_n, risk_valid_n;
  logic               memwr_n, ord_reject_n;
  logic               done_max, done_max_n;
  logic               push, pop, max_load, risk_pass;

  logic [QTY_W-1:0]   qty_mem   [DEPTH];
  logic [PRICE_W-1:0] price_mem [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [QTY_W+1:0]   risk_sum;
  logic [QTY_W:0]     push_amt, pop_amt;

  // Risk rule: non-zero quantity and projected exposure within the max.
  // The sum is formed one bit wider than exposure so it can never wrap.
  assign risk_sum  = {1'b0, exposure} + {2'b00, order_qty};
  assign risk_pass = (order_qty != '0) && (risk_sum <= {2'b00, cur_max});

  assign pop      = rd_en && (count != '0);
  assign rd_valid = (count != '0);
  assign buf_full = (count == CNT_DEPTH);
  assign rd_qty   = qty_mem[head];
  assign rd_price = price_mem[head];
  assign push_amt = push ? {1'b0, order_qty} : '0;
  assign pop_amt  = pop ? {1'b0, qty_mem[head]} : '0;

  // Next-state and registered-output decode for the handshake FSM.
  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    risk_stage_n = risk_stage;
    risk_ok_n    = risk_ok;
    risk_valid_n = risk_valid;
    memwr_n      = 1'b0;
    ord_reject_n = 1'b0;
    done_max_n   = done_max;
    push         = 1'b0;
    max_load     = 1'b0;
    case (state)
      IDLE: begin
        wcnt_n       = WC_LOAD;
        risk_stage_n = 1'b0;
        if (update_max)      state_n = MAX_WR;
        else if (send_order) state_n = ORD_WR;
        else if (check_risk) state_n = RISK;
      end
      RISK: begin
        if (!check_risk) begin
          risk_valid_n = 1'b0;
          risk_ok_n    = 1'b0;
          risk_stage_n = 1'b0;
          state_n      = IDLE;
        end else if (!risk_stage) begin
          risk_stage_n = 1'b1;
        end else if (!risk_valid) begin
          risk_valid_n = 1'b1;
          risk_ok_n    = risk_pass;
        end
      end
      ORD_WR: begin
        if (!send_order) begin
          state_n = IDLE;
        end else if (wcnt != '0) begin
          wcnt_n = wcnt - WC_ONE;
        end else if (!buf_full) begin
          memwr_n    = 1'b1;
          done_max_n = 1'b0;
          state_n    = DONE;
          if (risk_pass) push = 1'b1;
          else           ord_reject_n = 1'b1;
        end
      end
      MAX_WR: begin
        if (!update_max) begin
          state_n = IDLE;
        end else if (wcnt != '0) begin
          wcnt_n = wcnt - WC_ONE;
        end else begin
          max_load   = 1'b1;
          memwr_n    = 1'b1;
          done_max_n = 1'b1;
          state_n    = DONE;
        end
      end
      DONE: begin
        if (done_max ? !update_max : !send_order) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, handshake outputs, max register and buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      state      <= IDLE;
      wcnt       <= '0;
      risk_stage <= 1'b0;
      risk_ok    <= 1'b0;
      risk_valid <= 1'b0;
      memwr      <= 1'b0;
      ord_reject <= 1'b0;
      done_max   <= 1'b0;
      cur_max    <= QTY_W'(MAX_RESET);
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      exposure   <= '0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      risk_stage <= risk_stage_n;
      risk_ok    <= risk_ok_n;
      risk_valid <= risk_valid_n;
      memwr      <= memwr_n;
      ord_reject <= ord_reject_n;
      done_max   <= done_max_n;
      if (max_load) cur_max <= max_in;
      if (push)     tail <= tail + PTR_ONE;
      if (pop)      head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      exposure <= exposure + push_amt - pop_amt;
    end
  end

  // Buffer storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      qty_mem[tail]   <= order_qty;
      price_mem[tail] <= order_price;
    end
  end

endmodule

// File: tb/tb_risk_memory_responder.sv
// Directed bench for risk_memory_responder with hand-computed expectations.
module tb_risk_memory_responder;

  logic        clk = 1'b0;
  logic        HRESETn;
  logic        check_risk, send_order, update_max, rd_en;
  logic [15:0] order_qty, order_price, max_in;
  logic        risk_ok, risk_valid, memwr, ord_reject, rd_valid, buf_full;
  logic [15:0] cur_max, rd_qty, rd_price;
  logic [16:0] exposure;
  logic [3:0]  count;

  int total_checks = 0;
  int bad_checks   = 0;

  risk_memory_responder dut (
    .clk        (clk),
    .HRESETn    (HRESETn),
    .check_risk (check_risk),
    .send_order (send_order),
    .update_max (update_max),
    .order_qty  (order_qty),
    .order_price(order_price),
    .max_in     (max_in),
    .risk_ok    (risk_ok),
    .risk_valid (risk_valid),
    .memwr      (memwr),
    .ord_reject (ord_reject),
    .cur_max    (cur_max),
    .exposure   (exposure),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_qty     (rd_qty),
    .rd_price   (rd_price),
    .count      (count),
    .buf_full   (buf_full)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cr, input logic so, input logic um,
                               input int qty, input int price, input int mx);
    check_risk  = cr;
    send_order  = so;
    update_max  = um;
    order_qty   = 16'(qty);
    order_price = 16'(price);
    max_in      = 16'(mx);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    assert (observed === expected)
    else begin
      bad_checks++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Full write handshake: request, memwr after 3 ticks, drop, pulse gone.
  task automatic runWrite(input logic is_max, input int val, input int price,
                          input logic exp_rej, input string tag);
    if (is_max) applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, val);
    else        applyStimulus(1'b0, 1'b1, 1'b0, val, price, 0);
    tick(3);
    checkOutput({tag, "_memwr"}, 32'(memwr), 1);
    checkOutput({tag, "_rej"}, 32'(ord_reject), 32'(exp_rej));
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(1);
    checkOutput({tag, "_memwr_end"}, 32'(memwr), 0);
  endtask

  // Risk check: valid exactly two cycles after IDLE samples the request.
  task automatic runRisk(input int qty, input logic exp_ok, input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, qty, 0, 0);
    tick(2);
    checkOutput({tag, "_early"}, 32'(risk_valid), 0);
    tick(1);
    checkOutput({tag, "_valid"}, 32'(risk_valid), 1);
    checkOutput({tag, "_ok"}, 32'(risk_ok), 32'(exp_ok));
    tick(1);
    checkOutput({tag, "_hold"}, 32'(risk_ok), 32'(exp_ok));
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(1);
    checkOutput({tag, "_clr_valid"}, 32'(risk_valid), 0);
    checkOutput({tag, "_clr_ok"}, 32'(risk_ok), 0);
  endtask

  // Pop the head once.
  task automatic popOnce();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    HRESETn = 1'b0;
    rd_en   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(2);
    HRESETn = 1'b1;
    checkOutput("rst_risk_valid", 32'(risk_valid), 0);
    checkOutput("rst_risk_ok", 32'(risk_ok), 0);
    checkOutput("rst_memwr", 32'(memwr), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_exposure", 32'(exposure), 0);
    checkOutput("rst_cur_max", 32'(cur_max), 1000);
    checkOutput("rst_rd_valid", 32'(rd_valid), 0);
    checkOutput("rst_buf_full", 32'(buf_full), 0);

    $display("[TB] risk checks");
    runRisk(400, 1'b1, "risk400");
    runRisk(0, 1'b0, "risk0");
    runRisk(1000, 1'b1, "risk_edge");
    runRisk(1001, 1'b0, "risk_over");

    $display("[TB] order writes");
    runWrite(1'b0, 600, 55, 1'b0, "ord600");
    checkOutput("ord600_count", 32'(count), 1);
    checkOutput("ord600_exp", 32'(exposure), 600);
    checkOutput("ord600_rdq", 32'(rd_qty), 600);
    checkOutput("ord600_rdp", 32'(rd_price), 55);
    checkOutput("ord600_rdv", 32'(rd_valid), 1);
    runWrite(1'b0, 500, 66, 1'b1, "ord500");
    checkOutput("ord500_count", 32'(count), 1);
    checkOutput("ord500_exp", 32'(exposure), 600);

    $display("[TB] max update");
    runWrite(1'b1, 2000, 0, 1'b0, "max2000");
    checkOutput("max2000_val", 32'(cur_max), 2000);
    runWrite(1'b0, 1300, 11, 1'b0, "ord1300");
    checkOutput("ord1300_count", 32'(count), 2);
    checkOutput("ord1300_exp", 32'(exposure), 1900);

    // update_max and send_order together: max first, order after DONE.
    applyStimulus(1'b0, 1'b1, 1'b1, 100, 22, 3000);
    tick(3);
    checkOutput("both_memwr1", 32'(memwr), 1);
    checkOutput("both_max", 32'(cur_max), 3000);
    checkOutput("both_count1", 32'(count), 2);
    update_max = 1'b0;
    tick(1);
    checkOutput("both_gap", 32'(memwr), 0);
    tick(3);
    checkOutput("both_memwr2", 32'(memwr), 1);
    checkOutput("both_count2", 32'(count), 3);
    checkOutput("both_exp", 32'(exposure), 2000);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(1);

    // Push coinciding with a pop: count unchanged, exposure nets out.
    applyStimulus(1'b0, 1'b1, 1'b0, 50, 9, 0);
    tick(2);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    checkOutput("pp_memwr", 32'(memwr), 1);
    checkOutput("pp_count", 32'(count), 3);
    checkOutput("pp_exp", 32'(exposure), 1450);
    checkOutput("pp_rdq", 32'(rd_qty), 1300);
    checkOutput("pp_rdp", 32'(rd_price), 11);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(1);

    popOnce();
    checkOutput("drain1_exp", 32'(exposure), 150);
    checkOutput("drain1_rdq", 32'(rd_qty), 100);
    popOnce();
    checkOutput("drain2_exp", 32'(exposure), 50);
    checkOutput("drain2_rdp", 32'(rd_price), 9);
    popOnce();
    checkOutput("drain3_count", 32'(count), 0);
    checkOutput("drain3_exp", 32'(exposure), 0);
    popOnce();
    checkOutput("empty_pop_count", 32'(count), 0);
    checkOutput("empty_pop_exp", 32'(exposure), 0);

    $display("[TB] fill and stall");
    runWrite(1'b1, 1000, 0, 1'b0, "max1000");
    for (int i = 0; i < 8; i++) runWrite(1'b0, 1, i, 1'b0, "fill");
    checkOutput("fill_count", 32'(count), 8);
    checkOutput("fill_full", 32'(buf_full), 1);
    checkOutput("fill_exp", 32'(exposure), 8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 99, 0);
    tick(3);
    checkOutput("stall_memwr_a", 32'(memwr), 0);
    tick(2);
    checkOutput("stall_memwr_b", 32'(memwr), 0);
    checkOutput("stall_count", 32'(count), 8);
    popOnce();
    checkOutput("stall_pop_count", 32'(count), 7);
    checkOutput("stall_pop_memwr", 32'(memwr), 0);
    checkOutput("stall_pop_rdp", 32'(rd_price), 1);
    tick(1);
    checkOutput("stall_done_memwr", 32'(memwr), 1);
    checkOutput("stall_done_count", 32'(count), 8);
    checkOutput("stall_done_exp", 32'(exposure), 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(1);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("wrap_rdp", 32'(rd_price), (i < 8) ? i : 99);
      popOnce();
    end
    checkOutput("wrap_count", 32'(count), 0);
    checkOutput("wrap_exp", 32'(exposure), 0);

    $display("[TB] reset mid-write");
    runWrite(1'b1, 700, 0, 1'b0, "max700");
    runWrite(1'b0, 10, 1, 1'b0, "ord10");
    checkOutput("ord10_count", 32'(count), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 20, 2, 0);
    tick(2);
    HRESETn = 1'b0;
    tick(1);
    checkOutput("mrst_memwr", 32'(memwr), 0);
    checkOutput("mrst_count", 32'(count), 0);
    checkOutput("mrst_exp", 32'(exposure), 0);
    checkOutput("mrst_max", 32'(cur_max), 1000);
    checkOutput("mrst_rdv", 32'(rd_valid), 0);
    checkOutput("mrst_risk_valid", 32'(risk_valid), 0);
    HRESETn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick(1);
    checkOutput("mrst_late_memwr", 32'(memwr), 0);

    $display("[TB] abort mid-write");
    applyStimulus(1'b0, 1'b1, 1'b0, 30, 3, 0);
    tick(1);
    send_order = 1'b0;
    tick(1);
    checkOutput("abort_memwr_a", 32'(memwr), 0);
    tick(2);
    checkOutput("abort_memwr_b", 32'(memwr), 0);
    checkOutput("abort_count", 32'(count), 0);
    runWrite(1'b0, 30, 3, 1'b0, "after_abort");
    checkOutput("after_abort_count", 32'(count), 1);
    checkOutput("after_abort_exp", 32'(exposure), 30);
    checkOutput("after_abort_rdq", 32'(rd_qty), 30);

    // Max lowered below current exposure: checks now fail.
    runWrite(1'b1, 20, 0, 1'b0, "max20");
    checkOutput("max20_val", 32'(cur_max), 20);
    runRisk(1, 1'b0, "risk_lowmax");

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
